cordic_sincos: RTL and testbench
================================

CORDIC_SINCOS -- requirements
Module: cordic_sincos

Interface
REQ-001 SHALL expose parameters, one per line:
- DIN_WIDTH, 16: angle width, binary-angle format where the full range 2^DIN_WIDTH spans [-pi, pi).
- DOUT_WIDTH, 18: cos/sin width, signed, 2 integer bits including sign, DOUT_WIDTH-2 fractional bits.
- ITERS, 16: CORDIC micro-rotations, valid range 8..DOUT_WIDTH-2.

REQ-002 SHALL expose ports, one per line:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when low, all state freezes.
- din  in  DIN_WIDTH  signed angle.
- din_valid  in  1  angle present.
- din_ready  out  1  block can accept an angle.
- cos_out  out  DOUT_WIDTH  cosine of the last accepted angle.
- sin_out  out  DOUT_WIDTH  sine of the last accepted angle.
- dout_valid  out  1  one-cycle result strobe.

Function
REQ-003 SHALL accept an angle only on a cycle with ce=1, din_valid=1 and din_ready=1.
REQ-004 SHALL implement three states:
- IDLE: din_ready=1. Go to ROT on accept.
- ROT: din_ready=0. Perform one micro-rotation per ce cycle. Go to DONE after ITERS rotations.
- DONE: on the next ce cycle, drive outputs, strobe dout_valid and return to IDLE.
REQ-005 SHALL, on accept, pre-rotate by quadrant using din[DIN_WIDTH-1:DIN_WIDTH-2]:
- Angles in [pi/2, pi) or [-pi, -pi/2): subtract or add pi, and record a negate flag.
- Otherwise: negate flag cleared.
REQ-006 SHALL initialise x = round(0.6072529350 * 2^(DOUT_WIDTH-2)) and y = 0; z = pre-rotated angle, sign-extended by 2 guard bits.
REQ-007 SHALL, at iteration i, compute d = sign(z):
- x -= d*(y>>>i); y += d*(x>>>i); z -= d*atan(2^-i).
- All three updates use the previous-cycle values.
- Shifts are arithmetic.
- atan values come from an internal constant table in binary-angle units (atan(1) = 2^(DIN_WIDTH-3)).
REQ-008 SHALL keep x and y in DOUT_WIDTH+2 bits internally to absorb CORDIC gain overshoot; the final result is truncated to DOUT_WIDTH after negation.
REQ-009 SHALL negate x and y at DONE when the negate flag is set.
REQ-010 SHALL give a latency of exactly ITERS+2 ce-enabled cycles from the accept edge to the dout_valid edge.
REQ-011 SHALL accept a new angle in IDLE on the cycle after dout_valid, giving a sustained throughput of one result per ITERS+2 ce cycles.
REQ-012 SHALL hold cos_out and sin_out stable from the dout_valid edge until the next dout_valid edge.
REQ-013 SHALL ignore din_valid while din_ready=0; no queuing, the angle is dropped.
REQ-014 SHALL, when ce is low in any state, hold all state and outputs; dout_valid SHALL be 0 during such cycles and SHALL NOT be lost, so the strobe occurs on the next ce=1 cycle in DONE.
REQ-015 SHALL map din = -2^(DIN_WIDTH-1) (-pi) and din = 2^(DIN_WIDTH-2) (+pi/2) with no wrap error; the pre-rotation arithmetic wraps modulo 2^DIN_WIDTH.

Reset
REQ-016 SHALL, while rst_n=0, immediately force:
- state = IDLE, iteration counter = 0, negate flag = 0.
- din_ready = 0, dout_valid = 0, cos_out = 0, sin_out = 0.
REQ-017 SHALL set din_ready=1 on the first clk edge after rst_n deasserts.
REQ-018 SHALL, when reset asserts mid-rotation, discard the in-flight angle; no dout_valid for it SHALL ever appear.

Configuration
REQ-019 SHALL provide macro CORDIC_SAT_EN, which controls output saturation:
- Defined: clamp cos_out and sin_out to ±2^(DOUT_WIDTH-2) (±1.0) before registering.
- Undefined: truncation only, so results may exceed ±1.0 by a few LSB.

Verification
REQ-020 SHALL cover these directed scenarios (DIN_WIDTH=16, DOUT_WIDTH=18, ITERS=16, tolerance ±8 LSB):
- din=0x0000 -> cos_out≈65536, sin_out≈0, dout_valid exactly 18 cycles after accept.
- din=0x4000 (pi/2) -> cos_out≈0, sin_out≈65536; din=0x2000 (pi/4) -> both ≈46341.
- din=0x8000 (-pi) -> cos_out≈-65536, sin_out≈0; din=0xC000 (-pi/2) -> sin_out≈-65536.
- Back-to-back din_valid held high -> one dout_valid per 18 cycles; angles offered while din_ready=0 are dropped.
- ce toggled 50% during rotation -> identical result, latency = 18 ce=1 cycles, single dout_valid.
- rst_n pulsed low at iteration 7 -> outputs zero immediately, no dout_valid, next angle computed correctly.
- With CORDIC_SAT_EN defined, din=0x0000 -> cos_out ≤ 65536.

Source files
------------

// File: rtl/cordic_sincos_if.sv
// Angle-in / cosine-sine-out handshake bundle for cordic_sincos.
interface cordic_sincos_if #(
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 18
);
    logic signed [DIN_WIDTH-1:0]  din;
    logic                         din_valid;
    logic                         din_ready;
    logic signed [DOUT_WIDTH-1:0] cos_out;
    logic signed [DOUT_WIDTH-1:0] sin_out;
    logic                         dout_valid;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  cos_out,
        input  sin_out,
        input  dout_valid
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output cos_out,
        output sin_out,
        output dout_valid
    );
endinterface

// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine: one micro-rotation per enabled clock, result every ITERS+2 cycles.
// Optional macro CORDIC_SAT_EN clamps cos/sin to +/-1.0; without it results are truncated only.
module cordic_sincos #(
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 18,
    parameter int ITERS      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    cordic_sincos_if.slave bus
);

    localparam int XW = DOUT_WIDTH + 2;
    localparam int ZF = 8;
    localparam int ZW = DIN_WIDTH + 2 + ZF;
    localparam int CW = $clog2(ITERS + 1);
    localparam int SH = 32 - DIN_WIDTH - ZF;
    localparam logic signed [XW-1:0] X_INIT =
        XW'($rtoi(0.6072529350 * (2.0 ** (DOUT_WIDTH - 2)) + 0.5));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // atan(2^-i) with a full turn = 2^32; rescaled below to the working angle format.
    function automatic logic [31:0] atan_lut(input logic [CW-1:0] idx);
        logic [5:0] i6;
        i6 = 6'(idx);
        case (i6)
            6'd0:    return 32'h20000000;
            6'd1:    return 32'h12E4051E;
            6'd2:    return 32'h09FB385B;
            6'd3:    return 32'h051111D4;
            6'd4:    return 32'h028B0D43;
            6'd5:    return 32'h0145D7E1;
            6'd6:    return 32'h00A2F61E;
            6'd7:    return 32'h00517C55;
            6'd8:    return 32'h0028BE53;
            6'd9:    return 32'h00145F2F;
            6'd10:   return 32'h000A2F98;
            6'd11:   return 32'h000517CC;
            6'd12:   return 32'h00028BE6;
            6'd13:   return 32'h000145F3;
            6'd14:   return 32'h0000A2FA;
            6'd15:   return 32'h0000517D;
            6'd16:   return 32'h000028BE;
            6'd17:   return 32'h0000145F;
            6'd18:   return 32'h00000A30;
            6'd19:   return 32'h00000518;
            6'd20:   return 32'h0000028C;
            6'd21:   return 32'h00000146;
            6'd22:   return 32'h000000A3;
            6'd23:   return 32'h00000051;
            default: return 32'd683565276 >> i6;
        endcase
    endfunction

    // z keeps ZF fractional angle bits so table rounding does not pile up over the iterations.
    function automatic logic signed [ZW-1:0] atan_z(input logic [CW-1:0] idx);
        logic [32:0] rnd;
        rnd = {1'b0, atan_lut(idx)} + (33'd1 << (SH - 1));
        return $signed(ZW'(rnd >> SH));
    endfunction

`ifdef CORDIC_SAT_EN
    localparam logic signed [XW-1:0] ONE_X =
        {{(XW - DOUT_WIDTH + 1){1'b0}}, 1'b1, {(DOUT_WIDTH - 2){1'b0}}};

    function automatic logic signed [DOUT_WIDTH-1:0] sat_out(input logic signed [XW-1:0] v);
        if (v > ONE_X) begin
            return DOUT_WIDTH'(ONE_X);
        end else if (v < -ONE_X) begin
            return DOUT_WIDTH'(-ONE_X);
        end else begin
            return DOUT_WIDTH'(v);
        end
    endfunction
`endif

    state_t                       state_q, state_d;
    logic [CW-1:0]                iter_q, iter_d;
    logic                         neg_q, neg_d;
    logic signed [XW-1:0]         x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]         z_q, z_d;
    logic signed [DOUT_WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;
    logic                         dv_q, dv_d;
    logic                         rdy_q, rdy_d;

    logic                         accept_s;
    logic [1:0]                   quad_s;
    logic                         neg_in_s;
    logic [DIN_WIDTH-1:0]         zin_s;
    logic signed [XW-1:0]         x_sh_s, y_sh_s, x_rot_s, y_rot_s, x_fin_s, y_fin_s;
    logic signed [ZW-1:0]         at_s, z_rot_s;
    logic signed [DOUT_WIDTH-1:0] cos_fin_s, sin_fin_s;

    assign accept_s = ce & bus.din_valid & rdy_q;

    // Quadrant fold: flipping the MSB adds pi modulo a full turn, so +/-pi share one path.
    always_comb begin
        quad_s = bus.din[DIN_WIDTH-1 -: 2];
        case (quad_s)
            2'b01, 2'b10: begin
                zin_s    = {~bus.din[DIN_WIDTH-1], bus.din[DIN_WIDTH-2:0]};
                neg_in_s = 1'b1;
            end
            default: begin
                zin_s    = bus.din;
                neg_in_s = 1'b0;
            end
        endcase
    end

    // Micro-rotation datapath and final sign/format stage.
    always_comb begin
        x_sh_s = x_q >>> iter_q;
        y_sh_s = y_q >>> iter_q;
        at_s   = atan_z(iter_q);
        if (z_q[ZW-1]) begin
            x_rot_s = x_q + y_sh_s;
            y_rot_s = y_q - x_sh_s;
            z_rot_s = z_q + at_s;
        end else begin
            x_rot_s = x_q - y_sh_s;
            y_rot_s = y_q + x_sh_s;
            z_rot_s = z_q - at_s;
        end
        if (neg_q) begin
            x_fin_s = -x_q;
            y_fin_s = -y_q;
        end else begin
            x_fin_s = x_q;
            y_fin_s = y_q;
        end
`ifdef CORDIC_SAT_EN
        cos_fin_s = sat_out(x_fin_s);
        sin_fin_s = sat_out(y_fin_s);
`else
        cos_fin_s = DOUT_WIDTH'(x_fin_s);
        sin_fin_s = DOUT_WIDTH'(y_fin_s);
`endif
    end

    // Control FSM and next-state of every register; nothing moves while ce is low.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        neg_d   = neg_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        dv_d    = 1'b0;
        rdy_d   = rdy_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        state_d = S_ROT;
                        iter_d  = '0;
                        neg_d   = neg_in_s;
                        x_d     = X_INIT;
                        y_d     = '0;
                        z_d     = {{2{zin_s[DIN_WIDTH-1]}}, zin_s, {ZF{1'b0}}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ROT: begin
                    x_d = x_rot_s;
                    y_d = y_rot_s;
                    z_d = z_rot_s;
                    if (iter_q == CW'(ITERS - 1)) begin
                        state_d = S_DONE;
                        iter_d  = '0;
                    end else begin
                        iter_d = iter_q + CW'(1);
                    end
                end
                S_DONE: begin
                    cos_d   = cos_fin_s;
                    sin_d   = sin_fin_s;
                    dv_d    = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    iter_d  = '0;
                    neg_d   = 1'b0;
                end
            endcase
            rdy_d = (state_d == S_IDLE);
        end else begin
            dv_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            neg_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            dv_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            neg_q   <= neg_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            dv_q    <= dv_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.din_ready  = rdy_q;
    assign bus.dout_valid = dv_q;
    assign bus.cos_out    = cos_q;
    assign bus.sin_out    = sin_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed self-checking bench for cordic_sincos with hand-computed sin/cos values.
module tb_cordic_sincos;
    localparam int DW  = 16;
    localparam int OW  = 18;
    localparam int IT  = 16;
    localparam int TOL = 8;
    localparam int LAT = IT + 2;

    logic clk;
    logic rst_n;
    logic ce;

    cordic_sincos_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus_if ();

    cordic_sincos #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .ITERS(IT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .bus   (bus_if)
    );

    int n_tests  = 0;
    int n_fail   = 0;
    int dv_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.dout_valid === 1'b1) dv_count++;
    end

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        n_tests++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
        end
    endtask

    // Latency counts ce=1 edges from the accept edge through the strobe edge, both inclusive.
    task automatic run_angle(input logic [DW-1:0] ang, input bit toggle_ce,
                             output int cs, output int sn, output int lat, output int found);
        int waited;
        cs = 0; sn = 0; lat = 0; found = 0; waited = 0;
        @(negedge clk);
        while (bus_if.din_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        bus_if.din       = ang;
        bus_if.din_valid = 1'b1;
        ce               = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 bus_if.din_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (toggle_ce) ce = ~ce;
            @(posedge clk);
            if (ce) lat++;
            #1;
            if (bus_if.dout_valid === 1'b1) begin
                cs    = bus_if.cos_out;
                sn    = bus_if.sin_out;
                found = 1;
                break;
            end
        end
        ce = 1'b1;
    endtask

    logic [DW-1:0] vec_ang [8] = '{16'h0000, 16'h4000, 16'h2000, 16'h8000,
                                   16'hC000, 16'h6000, 16'hA000, 16'hE000};
    int vec_cos [8] = '{65536, 0, 46341, -65536, 0, -46341, -46341, 46341};
    int vec_sin [8] = '{0, 65536, 46341, 0, -65536, 46341, -46341, -46341};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cs, sn, lat, found, dv_before;
        clk = 1'b0;
        rst_n = 1'b1;
        ce = 1'b1;
        bus_if.din = '0;
        bus_if.din_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_ready", int'(bus_if.din_ready), 0, 0);
        check_val("rst_valid", int'(bus_if.dout_valid), 0, 0);
        check_val("rst_cos", int'(bus_if.cos_out), 0, 0);
        check_val("rst_sin", int'(bus_if.sin_out), 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_val("ready_before_edge", int'(bus_if.din_ready), 0, 0);
        @(posedge clk);
        #1 check_val("ready_first_edge", int'(bus_if.din_ready), 1, 0);

        for (int v = 0; v < 8; v++) begin
            run_angle(vec_ang[v], 1'b0, cs, sn, lat, found);
            check_val($sformatf("found_%h", vec_ang[v]), found, 1, 0);
            check_val($sformatf("cos_%h", vec_ang[v]), cs, vec_cos[v], TOL);
            check_val($sformatf("sin_%h", vec_ang[v]), sn, vec_sin[v], TOL);
            check_val($sformatf("lat_%h", vec_ang[v]), lat, LAT, 0);
        end
        repeat (5) @(negedge clk);
        check_val("hold_cos", int'(bus_if.cos_out), 46341, TOL);
        check_val("hold_sin", int'(bus_if.sin_out), -46341, TOL);

        begin : b2b
            logic [DW-1:0] seq [3] = '{16'h0000, 16'hC000, 16'h2000};
            int exp_c [3] = '{65536, 0, 46341};
            int exp_s [3] = '{0, -65536, 46341};
            int idx, got, last_dv, cyc;
            idx = 0; got = 0; last_dv = 0; cyc = 0;
            @(negedge clk);
            for (int c = 0; c < 4 * LAT; c++) begin
                if (bus_if.dout_valid === 1'b1) begin
                    if (got < 3) begin
                        check_val($sformatf("b2b_cos%0d", got), int'(bus_if.cos_out), exp_c[got], TOL);
                        check_val($sformatf("b2b_sin%0d", got), int'(bus_if.sin_out), exp_s[got], TOL);
                        if (got > 0) check_val($sformatf("b2b_gap%0d", got), cyc - last_dv, LAT, 0);
                    end
                    last_dv = cyc;
                    got++;
                end
                if (bus_if.din_ready === 1'b1 && idx < 3) begin
                    bus_if.din       = seq[idx];
                    bus_if.din_valid = 1'b1;
                    idx++;
                end else if (bus_if.din_ready === 1'b1) begin
                    bus_if.din_valid = 1'b0;
                end else begin
                    bus_if.din = 16'h4000;
                end
                @(negedge clk);
                cyc++;
            end
            bus_if.din_valid = 1'b0;
            check_val("b2b_count", got, 3, 0);
        end

        dv_before = dv_count;
        run_angle(16'h2000, 1'b1, cs, sn, lat, found);
        check_val("ce_found", found, 1, 0);
        check_val("ce_cos", cs, 46341, TOL);
        check_val("ce_sin", sn, 46341, TOL);
        check_val("ce_lat", lat, LAT, 0);
        repeat (4) @(negedge clk);
        check_val("ce_strobes", dv_count - dv_before, 1, 0);

        @(negedge clk);
        bus_if.din       = 16'h4000;
        bus_if.din_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.din_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_cos", int'(bus_if.cos_out), 0, 0);
        check_val("midrst_sin", int'(bus_if.sin_out), 0, 0);
        check_val("midrst_ready", int'(bus_if.din_ready), 0, 0);
        dv_before = dv_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 10) @(negedge clk);
        check_val("midrst_no_strobe", dv_count - dv_before, 0, 0);
        run_angle(16'h6000, 1'b0, cs, sn, lat, found);
        check_val("post_rst_cos", cs, -46341, TOL);
        check_val("post_rst_sin", sn, 46341, TOL);
        check_val("post_rst_lat", lat, LAT, 0);

`ifdef CORDIC_SAT_EN
        run_angle(16'h0000, 1'b0, cs, sn, lat, found);
        check_val("sat_cos_le_one", (cs <= 65536) ? 1 : 0, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
